// File: rtl/apb_arb_pkg.sv
// Shared types and default geometry for the two-requester APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Arbitrates two requesters onto one APB master port; every output is a flop.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              grant,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ready,
  input  logic                    m_error
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_ACCESS = ACCESS;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          armed;
  logic [1:0]    req_eff;
  logic [1:0]    win;
  logic          sel;
  logic          finish;

  // The requester being answered this cycle still holds req_valid; mask it
  // so it cannot be re-granted off its stale request.
  assign req_eff = req_valid & ~rsp_valid;
  assign sel     = win[1];
  assign finish  = m_ready || (cnt == CNT_LAST);

  rr_arb2 u_rr (
    .req  (req_eff),
    .last (last_grant),
    .gnt  (win)
  );

  // armed holds off the first grant until the second edge after reset release.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      grant      <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_error  <= 1'b0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      armed      <= 1'b0;
    end else begin
      armed     <= 1'b1;
      rsp_valid <= 2'b00;
      rsp_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (armed && (win != 2'b00)) begin
            state      <= S_SETUP;
            grant      <= win;
            last_grant <= sel;
            busy       <= 1'b1;
            PSELx      <= 1'b1;
            PENABLE    <= 1'b0;
            PWRITE     <= sel ? req_write[1] : req_write[0];
            PADDR      <= sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr[ADDR_WIDTH-1:0];
            PWDATA     <= sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata[DATA_WIDTH-1:0];
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          PENABLE <= 1'b1;
          cnt     <= '0;
        end
        S_ACCESS: begin
          if (finish) begin
            // A real ready wins over an expiring count on the same cycle.
            state     <= S_IDLE;
            grant     <= 2'b00;
            rsp_valid <= grant;
            rsp_rdata <= m_ready ? m_rdata : '0;
            rsp_error <= m_ready ? m_error : 1'b1;
            busy      <= 1'b0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant   <= 2'b00;
          busy    <= 1'b0;
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 4, PADDR width in 128-bit words.
REQ-002 Parameter DATA_WIDTH, 128, PWDATA/m_rdata width.
REQ-003 Parameter TIMEOUT, 16, maximum ACCESS cycles without m_ready before abort.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed below.
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request level, held until own rsp_valid.
- req_write  in  2  per-requester direction (1=write).
- req_addr  in  2*ADDR_WIDTH  requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  2  one-hot owner of the current transfer, 0 when idle.
- rsp_valid  out  2  one-cycle completion pulse to the owner.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_error  out  1  error flag, valid with rsp_valid.
- busy  out  1  high in SETUP and ACCESS.
- PSELx, PENABLE, PWRITE  out  1 each  APB control toward the slave subsystem.
- PADDR  out  ADDR_WIDTH  latched address.
- PWDATA  out  DATA_WIDTH  latched write data.
- m_rdata  in  DATA_WIDTH  slave read data.
- m_ready  in  1  slave ready.
- m_error  in  1  slave error.

Function
REQ-005 The FSM SHALL have three states: IDLE, SETUP and ACCESS. All outputs SHALL be registered.
REQ-006 In IDLE, if any req_valid bit is 1, the block SHALL do all of the following on the next edge: select the winner, set grant, latch that requester's write/addr/wdata into PWRITE/PADDR/PWDATA, drive PSELx=1 and PENABLE=0, and enter SETUP.
REQ-007 Arbitration SHALL be round-robin. A single requester wins outright. When both request, the winner is the requester not granted last. last_grant resets to 1, so requester 0 wins the first tie.
REQ-008 From SETUP, the block SHALL enter ACCESS unconditionally on the next edge, with PENABLE=1 and PSELx=1. The timeout counter is cleared to 0.
REQ-009 In ACCESS with m_ready=1, the next edge SHALL:
- capture m_rdata into rsp_rdata and m_error into rsp_error;
- pulse rsp_valid[owner] for exactly one cycle;
- clear grant, PSELx and PENABLE;
- return to IDLE.
REQ-010 In ACCESS with m_ready=0, the block SHALL hold all APB outputs stable and increment the counter. If the counter reaches TIMEOUT-1, the next edge SHALL complete as in REQ-009, but with rsp_error=1 and rsp_rdata=0.
REQ-011 Latency SHALL be a minimum of 3 edges from req_valid sampled in IDLE to rsp_valid: SETUP, ACCESS, then completion.
REQ-012 After completion the block SHALL spend at least one cycle in IDLE. The completed requester's req_valid is ignored during that completion cycle.
REQ-013 req_* changes during SETUP or ACCESS SHALL NOT affect the latched transfer.
REQ-014 A requester deasserting req_valid before being granted SHALL simply lose its request; no response is produced.
REQ-015 PWDATA SHALL be latched for reads as well and is don't-care to the slave.

Reset
REQ-016 On PRESETn=0, the block SHALL asynchronously apply the following reset values:
- state=IDLE;
- grant=0, rsp_valid=0, rsp_error=0, busy=0;
- rsp_rdata=0, PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
- counter=0, last_grant=1.
REQ-017 Reset mid-transfer SHALL abort without any rsp_valid; requesters reissue after release.
REQ-018 The first grant SHALL occur no earlier than the second rising PCLK edge after PRESETn deasserts.

Structure
REQ-019 Package apb_arb_pkg SHALL hold the state enum typedef (IDLE, SETUP, ACCESS) and the default width/TIMEOUT constants.
REQ-020 The round-robin selection SHALL be a sub-module rr_arb2 (inputs req[1:0] and last; output one-hot gnt), instantiated once.

Verification
REQ-021 Requester 0 writes addr 4'h3, data 128'hA5…A5 with m_ready tied 1: bench SHALL see PSELx=1/PENABLE=0 for one cycle, then PENABLE=1 for one cycle, then rsp_valid[0] for one cycle, rsp_error=0, grant back to 0.
REQ-022 Both requesters assert in the same cycle after reset: bench SHALL see requester 0 served first, then requester 1, and on the next simultaneous pair requester 0 again.
REQ-023 Read from addr 4'h7 with m_ready low for 3 ACCESS cycles, then high with m_rdata=128'h1234: bench SHALL see APB outputs stable throughout, and rsp_rdata=128'h1234 with rsp_valid one edge after m_ready.
REQ-024 m_ready held 0 with TIMEOUT=16: bench SHALL see rsp_valid with rsp_error=1 and rsp_rdata=0 after exactly 16 ACCESS cycles.
REQ-025 m_error=1 with m_ready=1: bench SHALL see rsp_error=1 on the owner's pulse only.
REQ-026 PRESETn pulsed low during ACCESS: bench SHALL see all outputs 0 immediately, no rsp_valid, and a clean restart after release.
